// File: rtl/traffic_pkg.sv
// Shared definitions for the junction request front end: way count, event FSM
// encodings, default filter thresholds and the round-robin way picker.
package traffic_pkg;

    localparam int NUM_WAYS            = 4;
    localparam int WAY_W               = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_PRESENCE_CYCLES = 16;

    typedef logic [WAY_W-1:0] way_t;

    typedef enum logic {
        EVT_IDLE  = 1'b0,
        EVT_OFFER = 1'b1
    } evt_state_e;

    // First set bit of pend at or after ptr, wrapping around the four ways.
    function automatic way_t rr_pick(input logic [NUM_WAYS-1:0] pend, input way_t ptr);
        way_t pick;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            way_t idx;
            idx = way_t'(ptr + way_t'(k));
            if (!found && pend[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/traffic_request_frontend_input_debouncer.sv
// Two-flop synchroniser followed by a stable-sample filter. The output level
// flips once the synced input has disagreed with it for the threshold in force.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int RISE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FALL_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W       = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thr;

    // Rising and falling transitions may need different run lengths (vehicle presence).
    assign thr     = level_q ? CNT_W'(FALL_CYCLES) : CNT_W'(RISE_CYCLES);
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_inc == thr) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/traffic_request_frontend.sv
// Junction input front end: debounced button latches, qualified loop presence and a
// round-robin request event stream. TRAFFIC_REQ_STATS_EN enables the merge counter.
module traffic_request_frontend
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PRESENCE_CYCLES = DEF_PRESENCE_CYCLES,
    parameter int CNT_W           = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic [3:0] loop_raw,
    input  logic [3:0] served_ped,
    output logic [3:0] Button,
    output logic [3:0] V,
    output logic       evt_valid,
    output logic [1:0] evt_way,
    input  logic       evt_ready,
    output logic [7:0] merge_count
);

    logic [NUM_WAYS-1:0] btn_lvl;
    logic [NUM_WAYS-1:0] btn_prev_q;
    logic [NUM_WAYS-1:0] btn_set;
    logic [NUM_WAYS-1:0] button_q, button_d;
    logic [NUM_WAYS-1:0] pend_q, pend_d;
    logic [NUM_WAYS-1:0] hs_mask;
    logic                handshake;
    evt_state_e          state_q;
    logic                evt_valid_q;
    way_t                evt_way_q;
    way_t                rr_ptr_q;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        input_debouncer #(
            .RISE_CYCLES(DEBOUNCE_CYCLES),
            .FALL_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W      (CNT_W)
        ) u_btn (
            .clk_i  (clock),
            .rst_ni (reset),
            .raw_i  (btn_raw[g]),
            .level_o(btn_lvl[g])
        );

        input_debouncer #(
            .RISE_CYCLES(PRESENCE_CYCLES),
            .FALL_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W      (CNT_W)
        ) u_loop (
            .clk_i  (clock),
            .rst_ni (reset),
            .raw_i  (loop_raw[g]),
            .level_o(V[g])
        );
    end

    // A new request needs a debounced rising edge, an idle latch and no walk-green in progress;
    // the walk-green feedback always overrides a simultaneous set.
    assign btn_set   = btn_lvl & ~btn_prev_q & ~served_ped & ~button_q;
    assign button_d  = (button_q | btn_set) & ~served_ped;
    assign handshake = evt_valid_q & evt_ready;
    assign hs_mask   = handshake ? (NUM_WAYS'(1) << evt_way_q) : '0;
    assign pend_d    = (pend_q & ~hs_mask) | btn_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= '0;
            button_q   <= '0;
            pend_q     <= '0;
        end else begin
            btn_prev_q <= btn_lvl;
            button_q   <= button_d;
            pend_q     <= pend_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= EVT_IDLE;
            evt_valid_q <= 1'b0;
            evt_way_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            case (state_q)
                EVT_IDLE: begin
                    if (|pend_q) begin
                        evt_way_q   <= rr_pick(pend_q, rr_ptr_q);
                        evt_valid_q <= 1'b1;
                        state_q     <= EVT_OFFER;
                    end
                end
                EVT_OFFER: begin
                    if (evt_ready) begin
                        evt_valid_q <= 1'b0;
                        rr_ptr_q    <= way_t'(evt_way_q + way_t'(1));
                        state_q     <= EVT_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef TRAFFIC_REQ_STATS_EN
    logic [NUM_WAYS-1:0] merge_hits;
    logic [2:0]          n_merge;
    logic [8:0]          merge_sum;
    logic [7:0]          merge_q, merge_d;

    // A press landing on a way whose event is still pending (including the accept cycle) merges.
    assign merge_hits = btn_set & pend_q;
    assign n_merge    = 3'(merge_hits[0]) + 3'(merge_hits[1]) + 3'(merge_hits[2]) + 3'(merge_hits[3]);
    assign merge_sum  = {1'b0, merge_q} + 9'(n_merge);
    assign merge_d    = merge_sum[8] ? 8'hff : merge_sum[7:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            merge_q <= '0;
        end else begin
            merge_q <= merge_d;
        end
    end

    assign merge_count = merge_q;
`else
    assign merge_count = 8'd0;
`endif

    assign Button    = button_q;
    assign evt_valid = evt_valid_q;
    assign evt_way   = evt_way_q;

endmodule

// File: tb/tb_traffic_request_frontend.sv
// Directed bench for traffic_request_frontend with DEBOUNCE_CYCLES=4, PRESENCE_CYCLES=8.
module tb_traffic_request_frontend;

    logic       clock;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] loop_raw;
    logic [3:0] served_ped;
    logic [3:0] Button;
    logic [3:0] V;
    logic       evt_valid;
    logic [1:0] evt_way;
    logic       evt_ready;
    logic [7:0] merge_count;

    int errors;
    int checks;

    traffic_request_frontend #(
        .DEBOUNCE_CYCLES(4),
        .PRESENCE_CYCLES(8),
        .CNT_W          (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .loop_raw   (loop_raw),
        .served_ped (served_ped),
        .Button     (Button),
        .V          (V),
        .evt_valid  (evt_valid),
        .evt_way    (evt_way),
        .evt_ready  (evt_ready),
        .merge_count(merge_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        btn_raw    = '0;
        loop_raw   = '0;
        served_ped = '0;
        evt_ready  = 1'b0;
        reset      = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic settle();
        btn_raw    = '0;
        served_ped = 4'hf;
        tick(1);
        served_ped = '0;
        evt_ready  = 1'b1;
        tick(12);
        evt_ready  = 1'b0;
    endtask

    task automatic expect_sequence(input string tag, input int w0, input int w1, input int w2, input int w3);
        int exp_way[4];
        exp_way = '{w0, w1, w2, w3};
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check({tag, "_valid"}, evt_valid, 1);
            check({tag, "_way"}, evt_way, exp_way[k]);
            tick(1);
            check({tag, "_gap"}, evt_valid, 0);
        end
    endtask

    task automatic press_serve_way0();
        btn_raw[0] = 1'b1;
        tick(7);
        btn_raw[0]    = 1'b0;
        served_ped[0] = 1'b1;
        tick(1);
        served_ped[0] = 1'b0;
        tick(6);
    endtask

    initial begin
        int exp_small;
        int exp_sat;
        errors = 0;
        checks = 0;
        reset  = 1'b0;

        // 1: reset state, async reset while an event is offered
        do_reset();
        check("rst_button", Button, 0);
        check("rst_v", V, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_way", evt_way, 0);
        check("rst_merge", merge_count, 0);
        loop_raw[0] = 1'b1;
        btn_raw[1]  = 1'b1;
        tick(10);
        check("t1_offer_valid", evt_valid, 1);
        check("t1_offer_way", evt_way, 1);
        check("t1_v0", V, 4'b0001);
        btn_raw  = '0;
        loop_raw = '0;
        #2;
        reset = 1'b0;
        #1;
        check("t1_async_button", Button, 0);
        check("t1_async_v", V, 0);
        check("t1_async_valid", evt_valid, 0);
        check("t1_async_way", evt_way, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        btn_raw[2] = 1'b1;
        tick(8);
        check("t1_fresh_valid", evt_valid, 1);
        check("t1_fresh_way", evt_way, 2);
        check("t1_fresh_button", Button, 4'b0100);
        settle();
        check("t1_drained", evt_valid, 0);

        // 2: glitch rejection and press latency
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        tick(8);
        check("t2_glitch_button", Button, 0);
        check("t2_glitch_valid", evt_valid, 0);
        btn_raw[1] = 1'b1;
        tick(6);
        check("t2_edge6_button", Button, 0);
        tick(1);
        check("t2_edge7_button", Button, 4'b0010);
        check("t2_edge7_valid", evt_valid, 0);
        tick(1);
        check("t2_edge8_valid", evt_valid, 1);
        check("t2_edge8_way", evt_way, 1);
        settle();

        // 3: served feedback clears, and wins over a simultaneous set
        btn_raw[0] = 1'b1;
        tick(7);
        check("t3_button_set", Button, 4'b0001);
        served_ped[0] = 1'b1;
        tick(1);
        check("t3_served_clear", Button, 0);
        served_ped[0] = 1'b0;
        btn_raw[0]    = 1'b0;
        tick(8);
        btn_raw[0] = 1'b1;
        tick(6);
        served_ped[0] = 1'b1;
        tick(1);
        check("t3_clear_wins", Button, 0);
        served_ped[0] = 1'b0;
        tick(2);
        check("t3_no_late_set", Button, 0);
        settle();

        // 4: round-robin order from rr_ptr=0 and from rr_ptr=2
        do_reset();
        btn_raw   = 4'hf;
        evt_ready = 1'b1;
        tick(7);
        check("t4a_buttons", Button, 4'hf);
        expect_sequence("t4a", 0, 1, 2, 3);
        settle();
        btn_raw[1] = 1'b1;
        evt_ready  = 1'b1;
        tick(8);
        check("t4_single_way", evt_way, 1);
        check("t4_single_valid", evt_valid, 1);
        settle();
        btn_raw   = 4'hf;
        evt_ready = 1'b1;
        tick(7);
        expect_sequence("t4b", 2, 3, 0, 1);
        settle();

        // 5: asymmetric presence filter on loop 3
        loop_raw[3] = 1'b1;
        tick(7);
        loop_raw[3] = 1'b0;
        tick(10);
        check("t5_short_v", V, 0);
        loop_raw[3] = 1'b1;
        tick(9);
        check("t5_edge9_v", V, 0);
        tick(1);
        check("t5_edge10_v", V, 4'b1000);
        loop_raw[3] = 1'b0;
        tick(3);
        loop_raw[3] = 1'b1;
        tick(10);
        check("t5_dip_v", V, 4'b1000);
        loop_raw[3] = 1'b0;
        tick(5);
        check("t5_fall5_v", V, 4'b1000);
        tick(1);
        check("t5_fall6_v", V, 0);

        // 6: merge counter saturation with the event held unaccepted
`ifdef TRAFFIC_REQ_STATS_EN
        exp_small = 2;
        exp_sat   = 255;
`else
        exp_small = 0;
        exp_sat   = 0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) press_serve_way0();
        check("t6_merge_3", merge_count, exp_small);
        for (int i = 3; i < 300; i++) press_serve_way0();
        check("t6_merge_300", merge_count, exp_sat);
        check("t6_held_valid", evt_valid, 1);
        check("t6_held_way", evt_way, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
